// File: rtl/pc_fetch_unit_if.sv
// Fetch-side bundle: redirect input from next-PC select, instruction memory
// request/response channel and the decode handshake.
interface pc_fetch_unit_if #(
    parameter int XLEN = 32
) ();
    logic            Redirect;
    logic [XLEN-1:0] RedirectPc;
    logic            ImemReqValid;
    logic            ImemReqReady;
    logic [XLEN-1:0] ImemReqAddr;
    logic            ImemRspValid;
    logic [XLEN-1:0] ImemRspData;
    logic            InstrValid;
    logic            InstrReady;
    logic [XLEN-1:0] Instr;
    logic [XLEN-1:0] InstrPc;
    logic [XLEN-1:0] PcPlus4;
    logic            Misaligned;

    modport master (
        input  Redirect, RedirectPc, ImemReqReady, ImemRspValid, ImemRspData, InstrReady,
        output ImemReqValid, ImemReqAddr, InstrValid, Instr, InstrPc, PcPlus4, Misaligned
    );

    modport slave (
        output Redirect, RedirectPc, ImemReqReady, ImemRspValid, ImemRspData, InstrReady,
        input  ImemReqValid, ImemReqAddr, InstrValid, Instr, InstrPc, PcPlus4, Misaligned
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// PC register and single-outstanding instruction fetcher: REQ -> WAIT -> HOLD,
// with redirects taking priority in every state.
module pc_fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input logic             clk,
    input logic             rst_n,
    pc_fetch_unit_if.master bus
);
    localparam logic [1:0] ST_REQ  = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    logic [1:0]      state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            drop_q, drop_d;
    logic            instr_valid_q, instr_valid_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] instr_pc_q, instr_pc_d;
    logic            misaligned_q, misaligned_d;
    logic [XLEN-1:0] redirect_target;

    assign redirect_target = {bus.RedirectPc[XLEN-1:2], 2'b00};

    // A redirect during WAIT leaves the in-flight response stale; drop_q marks
    // it so the eventual response is discarded instead of decoded.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        drop_d        = drop_q;
        instr_valid_d = instr_valid_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        misaligned_d  = bus.Redirect && (bus.RedirectPc[1:0] != 2'b00);

        case (state_q)
            ST_REQ: begin
                if (bus.Redirect) pc_d = redirect_target;
                if (bus.ImemReqReady) begin
                    state_d = ST_WAIT;
                    drop_d  = bus.Redirect;
                end
            end
            ST_WAIT: begin
                if (bus.Redirect) pc_d = redirect_target;
                if (bus.ImemRspValid) begin
                    drop_d  = 1'b0;
                    state_d = ST_REQ;
                    if (!bus.Redirect && !drop_q) begin
                        instr_d       = bus.ImemRspData;
                        instr_pc_d    = pc_q;
                        instr_valid_d = 1'b1;
                        state_d       = ST_HOLD;
                    end
                end else if (bus.Redirect) begin
                    drop_d = 1'b1;
                end
            end
            ST_HOLD: begin
                if (bus.Redirect || bus.InstrReady) begin
                    instr_valid_d = 1'b0;
                    state_d       = ST_REQ;
                    pc_d          = bus.Redirect ? redirect_target : instr_pc_q + PC_STEP;
                end
            end
            default: state_d = ST_REQ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_REQ;
            pc_q          <= RESET_PC;
            drop_q        <= 1'b0;
            instr_valid_q <= 1'b0;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            misaligned_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            drop_q        <= drop_d;
            instr_valid_q <= instr_valid_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            misaligned_q  <= misaligned_d;
        end
    end

    // Request is gated by rst_n so nothing is issued while reset is held.
    assign bus.ImemReqValid = rst_n && (state_q == ST_REQ);
    assign bus.ImemReqAddr  = pc_q;
    assign bus.InstrValid   = instr_valid_q;
    assign bus.Instr        = instr_q;
    assign bus.InstrPc      = instr_pc_q;
    assign bus.PcPlus4      = instr_pc_q + PC_STEP;
    assign bus.Misaligned   = misaligned_q;
endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed scenarios then random traffic, checked
// against a transaction-level model (intended PC, one outstanding request, staleness).
module tb_pc_fetch_unit;
    localparam int          XLEN     = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    pc_fetch_unit_if #(.XLEN(XLEN)) bus ();

    pc_fetch_unit #(.XLEN(XLEN), .RESET_PC(RESET_PC)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int testsRun    = 0;
    int testsFailed = 0;

    logic        drvRedirect, drvReady, drvInstrReady, drvSpurious;
    logic [31:0] drvTarget;
    int          latCfg;
    bit          latRandom;
    bit          rspNow;

    logic [31:0] mPc, mOutAddr, mInstr, mInstrPc;
    bit          mOut, mStale, mValid, mMis;
    int          rspCnt;
    int          misSeen;
    logic [31:0] accQ[$];

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Abstract model: the fetcher aims at an intended PC, has at most one
    // request outstanding, and a redirect makes that request's response stale.
    task automatic modelEdge();
        bit expReqv, accept, resp, oldValid;
        if (!rst_n) begin
            mPc = RESET_PC; mOut = 0; mStale = 0; mValid = 0; mMis = 0;
            mInstr = '0; mInstrPc = '0; rspCnt = 0;
            return;
        end
        expReqv  = !mOut && !mValid;
        accept   = expReqv && drvReady;
        resp     = mOut && rspNow;
        oldValid = mValid;
        mMis     = drvRedirect && (drvTarget[1:0] != 2'b00);
        if (resp) begin
            if (!mStale && !drvRedirect) begin
                mValid   = 1;
                mInstr   = memWord(mOutAddr);
                mInstrPc = mOutAddr;
            end
            mOut   = 0;
            mStale = 0;
        end else if (mOut) begin
            if (drvRedirect) mStale = 1;
            rspCnt--;
        end
        if (accept) begin
            mOut     = 1;
            mOutAddr = mPc;
            mStale   = drvRedirect;
            rspCnt   = latRandom ? int'($urandom_range(1, 3)) : latCfg;
        end
        if (oldValid && (drvInstrReady || drvRedirect)) mValid = 0;
        if (drvRedirect) mPc = {drvTarget[31:2], 2'b00};
        else if (oldValid && drvInstrReady) mPc = mInstrPc + 32'd4;
    endtask

    task automatic checkAll();
        if (!rst_n) begin
            checkOutput("reqValidInReset", 32'(bus.ImemReqValid), 32'd0);
            checkOutput("instrValidInReset", 32'(bus.InstrValid), 32'd0);
        end else begin
            checkOutput("reqValid", 32'(bus.ImemReqValid), 32'(!mOut && !mValid));
            checkOutput("reqAddr", bus.ImemReqAddr, mPc);
            checkOutput("instrValid", 32'(bus.InstrValid), 32'(mValid));
            if (mValid) checkOutput("instr", bus.Instr, mInstr);
            checkOutput("instrPc", bus.InstrPc, mInstrPc);
            checkOutput("pcPlus4", bus.PcPlus4, mInstrPc + 32'd4);
            checkOutput("misaligned", 32'(bus.Misaligned), 32'(mMis));
            if (bus.Misaligned) misSeen++;
        end
    endtask

    // One clock: drive inputs (memory side from the model), log accepted
    // addresses, advance the model at the edge, check at the next negedge.
    task automatic applyStimulus();
        rspNow           = (mOut && rspCnt == 1) || (!mOut && drvSpurious);
        bus.ImemRspValid = rspNow;
        bus.ImemRspData  = mOut ? memWord(mOutAddr) : $urandom();
        bus.Redirect     = drvRedirect;
        bus.RedirectPc   = drvTarget;
        bus.ImemReqReady = drvReady;
        bus.InstrReady   = drvInstrReady;
        #1;
        if (bus.ImemReqValid && drvReady) accQ.push_back(bus.ImemReqAddr);
        @(posedge clk);
        modelEdge();
        @(negedge clk);
        checkAll();
    endtask

    task automatic doReset(input int n);
        rst_n = 1'b0;
        repeat (n) applyStimulus();
        rst_n = 1'b1;
    endtask

    task automatic waitHold(input string tag);
        for (int i = 0; i < 30 && !bus.InstrValid; i++) applyStimulus();
        checkOutput({tag, "Timeout"}, 32'(bus.InstrValid), 32'd1);
    endtask

    task automatic consumeOne();
        drvInstrReady = 1'b1;
        applyStimulus();
        drvInstrReady = 1'b0;
    endtask

    task automatic redirectOnce(input logic [31:0] target, input logic consume);
        drvRedirect   = 1'b1;
        drvTarget     = target;
        drvInstrReady = consume;
        applyStimulus();
        drvRedirect   = 1'b0;
        drvInstrReady = 1'b0;
    endtask

    initial begin
        drvRedirect = 0; drvReady = 0; drvInstrReady = 0; drvSpurious = 0;
        drvTarget = '0; latCfg = 1; latRandom = 0; misSeen = 0; rspNow = 0;
        mPc = RESET_PC; mOut = 0; mStale = 0; mValid = 0; mMis = 0;
        mInstr = '0; mInstrPc = '0; mOutAddr = '0; rspCnt = 0;
        bus.Redirect = 0; bus.RedirectPc = '0; bus.ImemReqReady = 0;
        bus.ImemRspValid = 0; bus.ImemRspData = '0; bus.InstrReady = 0;
        rst_n = 1'b0;
        @(negedge clk);
        doReset(3);

        drvReady = 1'b1;
        waitHold("hold0");
        checkOutput("firstInstrPc", bus.InstrPc, 32'h0);
        checkOutput("firstPcPlus4", bus.PcPlus4, 32'h4);
        consumeOne();
        waitHold("hold4");
        checkOutput("secondInstrPc", bus.InstrPc, 32'h4);
        consumeOne();
        waitHold("hold8");
        checkOutput("thirdInstrPc", bus.InstrPc, 32'h8);

        repeat (5) applyStimulus();
        checkOutput("stallInstrPc", bus.InstrPc, 32'h8);
        checkOutput("stallInstr", bus.Instr, memWord(32'h8));

        redirectOnce(32'h100, 1'b1);
        waitHold("hold100");
        checkOutput("accCount", 32'(accQ.size()), 32'd4);
        if (accQ.size() >= 4) begin
            checkOutput("acc0", accQ[0], 32'h0);
            checkOutput("acc1", accQ[1], 32'h4);
            checkOutput("acc2", accQ[2], 32'h8);
            checkOutput("acc3", accQ[3], 32'h100);
        end

        latCfg = 3;
        consumeOne();
        applyStimulus();
        redirectOnce(32'h200, 1'b0);
        repeat (2) applyStimulus();
        checkOutput("droppedValid", 32'(bus.InstrValid), 32'd0);
        latCfg = 1;
        waitHold("hold200");
        checkOutput("redirectWaitPc", bus.InstrPc, 32'h200);
        if (accQ.size() >= 2) begin
            checkOutput("accStale", accQ[accQ.size()-2], 32'h104);
            checkOutput("accRedirect", accQ[accQ.size()-1], 32'h200);
        end

        misSeen = 0;
        redirectOnce(32'h103, 1'b0);
        waitHold("holdMis");
        checkOutput("misPulses", 32'(misSeen), 32'd1);
        checkOutput("misAlignedPc", bus.InstrPc, 32'h100);

        redirectOnce(32'hFFFF_FFFC, 1'b1);
        waitHold("holdTop");
        checkOutput("topInstrPc", bus.InstrPc, 32'hFFFF_FFFC);
        checkOutput("topPcPlus4", bus.PcPlus4, 32'h0);
        consumeOne();
        waitHold("holdWrap");
        checkOutput("wrapInstrPc", bus.InstrPc, 32'h0);

        latCfg = 3;
        consumeOne();
        applyStimulus();
        applyStimulus();
        doReset(2);
        drvReady    = 1'b0;
        drvSpurious = 1'b1;
        applyStimulus();
        drvSpurious = 1'b0;
        checkOutput("lateRspIgnored", 32'(bus.InstrValid), 32'd0);
        checkOutput("reqAfterReset", 32'(bus.ImemReqValid), 32'd1);
        drvReady = 1'b1;
        latCfg   = 1;
        waitHold("holdReset");
        checkOutput("resetPc", bus.InstrPc, RESET_PC);
        if (accQ.size() >= 1) checkOutput("accReset", accQ[accQ.size()-1], RESET_PC);

        latRandom = 1;
        for (int i = 0; i < 2000; i++) begin
            drvRedirect   = ($urandom_range(0, 9) == 0);
            drvTarget     = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom();
            drvReady      = ($urandom_range(0, 9) < 7);
            drvInstrReady = ($urandom_range(0, 9) < 6);
            drvSpurious   = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 199) == 0) doReset(2);
            else applyStimulus();
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
